axi4_mem_ctrl: RTL and testbench

- AXI4 slave controller that sequences the single-port synchronous memory block (mem_en/mem_we/mem_addr/mem_wdata/mem_rdata, 1-cycle registered read).
- Accepts INCR bursts on the AXI write and read channels and arbitrates between them round-robin. Only one burst is in flight at a time.
- Converts AXI byte addresses to word addresses and issues per-beat memory accesses.
- Sits between the AXI interconnect and the memory.

---
 rtl/axi4_mem_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_axi4_mem_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_ctrl.sv
// AXI4 slave front-end for a single-port synchronous RAM: one INCR burst in flight at a time.
// Round-robin write/read arbitration; illegal bursts are drained without memory access and answered SLVERR.
module axi4_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [7:0]                arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  typedef enum logic [2:0] {IDLE, W_DATA, W_RESP, R_ISSUE, R_DATA} state_t;

  localparam logic       PRIO_WRITE  = 1'b0;
  localparam logic       PRIO_READ   = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         EW          = ADDR_WIDTH + 1;

  state_t                    state_q, state_d;
  logic                      prio_q, prio_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_reg_q, addr_reg_d;
  logic [7:0]                beat_cnt_q, beat_cnt_d;
  logic [7:0]                len_reg_q, len_reg_d;
  logic                      err_q, err_d;
  logic                      wlast_err_q, wlast_err_d;

  logic                      aw_acc, ar_acc, last_beat;
  logic [ADDR_WIDTH-1:0]     a_addr;
  logic [7:0]                a_len;
  logic [2:0]                a_size;
  logic [1:0]                a_burst;
  logic [EW-1:0]             end_word;
  logic                      a_err;

  assign aw_acc    = (state_q == IDLE) && awvalid && (!arvalid || prio_q == PRIO_WRITE);
  assign ar_acc    = (state_q == IDLE) && arvalid && (!awvalid || prio_q == PRIO_READ);
  assign last_beat = (beat_cnt_q == len_reg_q);

  // Fields of whichever channel wins; the range check is one bit wider so it cannot wrap.
  assign a_addr   = aw_acc ? awaddr  : araddr;
  assign a_len    = aw_acc ? awlen   : arlen;
  assign a_size   = aw_acc ? awsize  : arsize;
  assign a_burst  = aw_acc ? awburst : arburst;
  assign end_word = EW'(a_addr >> 2) + EW'(a_len);
  assign a_err    = (a_size != 3'd2) || (a_burst != 2'b01) || (a_addr[1:0] != 2'b00) ||
                    (end_word > EW'(MEM_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= PRIO_WRITE;
      addr_reg_q  <= '0;
      beat_cnt_q  <= '0;
      len_reg_q   <= '0;
      err_q       <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      addr_reg_q  <= addr_reg_d;
      beat_cnt_q  <= beat_cnt_d;
      len_reg_q   <= len_reg_d;
      err_q       <= err_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    addr_reg_d  = addr_reg_q;
    beat_cnt_d  = beat_cnt_q;
    len_reg_d   = len_reg_q;
    err_d       = err_q;
    wlast_err_d = wlast_err_q;
    case (state_q)
      IDLE: begin
        if (aw_acc || ar_acc) begin
          addr_reg_d = a_addr[MEM_ADDR_WIDTH+1:2];
          len_reg_d  = a_len;
          beat_cnt_d = '0;
          err_d      = a_err;
          if (aw_acc) state_d = W_DATA;
          else        state_d = a_err ? R_DATA : R_ISSUE;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          addr_reg_d = addr_reg_q + 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (wlast != last_beat) wlast_err_d = 1'b1;
          // Beat count, not wlast, terminates the burst.
          if (last_beat) state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) begin
          state_d     = IDLE;
          prio_d      = PRIO_READ;
          wlast_err_d = 1'b0;
        end
      end
      R_ISSUE: state_d = R_DATA;
      R_DATA: begin
        if (rready) begin
          if (last_beat) begin
            state_d = IDLE;
            prio_d  = PRIO_WRITE;
          end else begin
            addr_reg_d = addr_reg_q + 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
            state_d    = err_q ? R_DATA : R_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced idle while reset is held so an abandoned burst cannot touch memory.
  always_comb begin
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bresp     = RESP_OKAY;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    rresp     = RESP_OKAY;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      awready = aw_acc;
      arready = ar_acc;
      case (state_q)
        W_DATA: begin
          wready    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_reg_q;
          mem_wdata = wdata;
          mem_en    = wvalid && !err_q;
        end
        W_RESP: begin
          bvalid = 1'b1;
          bresp  = (err_q || wlast_err_q) ? RESP_SLVERR : RESP_OKAY;
        end
        R_ISSUE: begin
          mem_en   = 1'b1;
          mem_addr = addr_reg_q;
        end
        R_DATA: begin
          rvalid = 1'b1;
          rlast  = last_beat;
          rdata  = err_q ? '0 : mem_rdata;
          rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_mem_ctrl.sv
// Bench for axi4_mem_ctrl: bench-side RAM plus a word-array reference model of the expected contents.
module tb_axi4_mem_ctrl;
  localparam int DW = 32, AW = 12, MAW = 10, DEPTH = 1024, TMO = 100;

  logic clk = 1'b0, rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic mem_en, mem_we;
  logic [MAW-1:0] mem_addr;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int mem_en_cnt = 0;
  int checks = 0, failures = 0;
  logic [DW-1:0] rd_data_q[$];
  logic [1:0]    rd_resp_q[$];
  logic          rd_last_q[$];

  always #5 clk = ~clk;

  axi4_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port RAM with a registered read port that holds its output between reads.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_en_cnt <= mem_en_cnt + 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  function automatic bit model_err(input logic [AW-1:0] a, input logic [7:0] l,
                                   input logic [2:0] s, input logic [1:0] bu);
    return (s != 3'd2) || (bu != 2'b01) || (a[1:0] != 2'b00) || ((int'(a) / 4 + int'(l)) > DEPTH - 1);
  endfunction

  task automatic axi_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit use_rand, input logic [DW-1:0] base,
                           input int bad_last, input int abort_after, output logic [1:0] resp,
                           output int en, output bit bflag, output logic [75:0] rst_outs);
    int n, en0;
    bit err;
    err = model_err(addr, len, size, burst);
    en0 = mem_en_cnt; resp = 2'bxx; bflag = 1'b0; rst_outs = '0; en = 0;
    @(negedge clk);
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1; #1;
    n = 0;
    while (awready !== 1'b1 && n < TMO) begin @(negedge clk); #1; n++; end
    if (n >= TMO) begin checks++; failures++; $display("FAIL aw_timeout addr=%h", addr); end
    @(negedge clk); awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == abort_after) begin
        wdata = $urandom; wlast = 1'b0; wvalid = 1'b1; rst_n = 1'b0; #1;
        rst_outs = {awready, arready, wready, bvalid, rvalid, rlast, mem_en, mem_we,
                    bresp, rresp, rdata, mem_wdata};
        repeat (2) @(negedge clk);
        rst_n = 1'b1; wvalid = 1'b0;
        repeat (3) begin @(negedge clk); #1; if (bvalid !== 1'b0) bflag = 1'b1; end
        en = mem_en_cnt - en0;
        return;
      end
      wdata  = use_rand ? $urandom : base + DW'(b);
      wlast  = ((b == int'(len)) != (b == bad_last));
      wvalid = 1'b1; #1;
      n = 0;
      while (wready !== 1'b1 && n < TMO) begin @(negedge clk); #1; n++; end
      if (n >= TMO) begin checks++; failures++; $display("FAIL w_timeout beat=%0d", b); end
      if (!err) ref_mem[int'(addr) / 4 + b] = wdata;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; #1;
    bflag = (bvalid !== 1'b1);
    n = 0;
    while (bvalid !== 1'b1 && n < TMO) begin @(negedge clk); #1; n++; end
    if (n >= TMO) begin checks++; failures++; $display("FAIL b_timeout addr=%h", addr); end
    resp = bresp; bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    en = mem_en_cnt - en0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int stall_beat, input int stall_cyc,
                          output int lat, output int en, output int unstable);
    int n, en0;
    logic [DW-1:0] sd;
    logic sl;
    logic [1:0] sr;
    rd_data_q.delete(); rd_resp_q.delete(); rd_last_q.delete();
    en0 = mem_en_cnt; unstable = 0;
    @(negedge clk);
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1; #1;
    n = 0;
    while (arready !== 1'b1 && n < TMO) begin @(negedge clk); #1; n++; end
    if (n >= TMO) begin checks++; failures++; $display("FAIL ar_timeout addr=%h", addr); end
    @(negedge clk); arvalid = 1'b0; #1;
    lat = 1;
    while (rvalid !== 1'b1 && lat < TMO) begin @(negedge clk); #1; lat++; end
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (rvalid !== 1'b1 && n < TMO) begin @(negedge clk); #1; n++; end
      if (n >= TMO) begin checks++; failures++; $display("FAIL r_timeout beat=%0d", b); end
      if (b == stall_beat) begin
        sd = rdata; sl = rlast; sr = rresp;
        repeat (stall_cyc) begin
          @(negedge clk); #1;
          if (rvalid !== 1'b1 || rdata !== sd || rlast !== sl || rresp !== sr) unstable++;
        end
      end
      rd_data_q.push_back(rdata); rd_resp_q.push_back(rresp); rd_last_q.push_back(rlast);
      rready = 1'b1;
      @(negedge clk); rready = 1'b0; #1;
    end
    en = mem_en_cnt - en0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({awready, arready, wready} !== 3'b000) begin failures++;
      $display("FAIL reset_ready got=%b exp=000", {awready, arready, wready}); end
    checks++; if ({bvalid, rvalid, rlast} !== 3'b000) begin failures++;
      $display("FAIL reset_valid got=%b exp=000", {bvalid, rvalid, rlast}); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin failures++;
      $display("FAIL reset_mem_ctl got=%b exp=00", {mem_en, mem_we}); end
    checks++; if ({bresp, rresp} !== 4'b0000) begin failures++;
      $display("FAIL reset_resp got=%b exp=0000", {bresp, rresp}); end
    checks++; if (rdata !== '0 || mem_wdata !== '0) begin failures++;
      $display("FAIL reset_data rdata=%h mem_wdata=%h exp=0", rdata, mem_wdata); end
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_arbitration();
    int g[4];
    int cnt, n;
    g = '{default: -1};
    @(negedge clk);
    awaddr = 12'h100; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
    araddr = 12'h104; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    wdata = 32'h5A5A_0001; wlast = 1'b1; wvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    awvalid = 1'b1; arvalid = 1'b1; #1;
    checks++; if ({awready, arready} !== 2'b10) begin failures++;
      $display("FAIL arb_first got aw/ar=%b exp=10", {awready, arready}); end
    cnt = 0; n = 0;
    while (cnt < 4 && n < TMO) begin
      if (awready === 1'b1) begin g[cnt] = 0; cnt++; ref_mem[12'h100 / 4] = wdata; end
      else if (arready === 1'b1) begin g[cnt] = 1; cnt++; end
      if (cnt < 4) begin @(negedge clk); #1; end
      n++;
    end
    @(negedge clk); awvalid = 1'b0; arvalid = 1'b0;
    repeat (6) @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b0; rready = 1'b0;
    checks++; if (cnt !== 4) begin failures++; $display("FAIL arb_grants got=%0d exp=4", cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (g[i] !== i % 2) begin failures++;
        $display("FAIL arb_order idx=%0d got=%0d exp=%0d (0=W 1=R)", i, g[i], i % 2); end
    end
  endtask

  task automatic test_basic();
    logic [1:0] resp; int en, lat, unst; bit bf; logic [75:0] ro;
    axi_write(12'h010, 8'd3, 3'd2, 2'b01, 1'b0, 32'hA0, -1, -1, resp, en, bf, ro);
    checks++; if (resp !== 2'b00) begin failures++; $display("FAIL basic_bresp got=%b exp=00", resp); end
    checks++; if (en !== 4) begin failures++; $display("FAIL basic_w_mem_en got=%0d exp=4", en); end
    checks++; if (bf !== 1'b0) begin failures++; $display("FAIL basic_b_latency got=late exp=next_cycle"); end
    for (int b = 0; b < 4; b++) begin
      checks++; if (mem[4 + b] !== 32'hA0 + DW'(b)) begin failures++;
        $display("FAIL basic_mem word=%0d got=%h exp=%h", 4 + b, mem[4 + b], 32'hA0 + DW'(b)); end
    end
    axi_read(12'h010, 8'd3, 3'd2, 2'b01, -1, 0, lat, en, unst);
    checks++; if (lat !== 2) begin failures++; $display("FAIL basic_r_latency got=%0d exp=2", lat); end
    checks++; if (en !== 4) begin failures++; $display("FAIL basic_r_mem_en got=%0d exp=4", en); end
    for (int b = 0; b < 4; b++) begin
      checks++; if (rd_data_q[b] !== 32'hA0 + DW'(b) || rd_resp_q[b] !== 2'b00 || rd_last_q[b] !== (b == 3)) begin
        failures++; $display("FAIL basic_rbeat beat=%0d got=%h/%b/%b exp=%h/00/%b",
                             b, rd_data_q[b], rd_resp_q[b], rd_last_q[b], 32'hA0 + DW'(b), b == 3); end
    end
  endtask

  task automatic test_write_errors();
    logic [1:0] resp; int en, lat, unst; bit bf; logic [75:0] ro;
    axi_write(12'hFF8, 8'd3, 3'd2, 2'b01, 1'b1, '0, -1, -1, resp, en, bf, ro);
    checks++; if (resp !== 2'b10) begin failures++; $display("FAIL oob_bresp got=%b exp=10", resp); end
    checks++; if (en !== 0) begin failures++; $display("FAIL oob_mem_en got=%0d exp=0", en); end
    axi_read(12'hFF8, 8'd1, 3'd2, 2'b01, -1, 0, lat, en, unst);
    for (int b = 0; b < 2; b++) begin
      checks++; if (rd_data_q[b] !== ref_mem[1022 + b] || rd_resp_q[b] !== 2'b00) begin failures++;
        $display("FAIL oob_untouched word=%0d got=%h/%b exp=%h/00", 1022 + b, rd_data_q[b], rd_resp_q[b], ref_mem[1022 + b]); end
    end
    axi_write(12'h020, 8'd1, 3'd1, 2'b01, 1'b1, '0, -1, -1, resp, en, bf, ro);
    checks++; if (resp !== 2'b10 || en !== 0) begin failures++;
      $display("FAIL wsize_err got resp=%b en=%0d exp resp=10 en=0", resp, en); end
    axi_write(12'h040, 8'd2, 3'd2, 2'b01, 1'b1, '0, 1, -1, resp, en, bf, ro);
    checks++; if (resp !== 2'b10 || en !== 3) begin failures++;
      $display("FAIL wlast_early got resp=%b en=%0d exp resp=10 en=3", resp, en); end
    axi_write(12'h050, 8'd2, 3'd2, 2'b01, 1'b1, '0, 2, -1, resp, en, bf, ro);
    checks++; if (resp !== 2'b10 || en !== 3 || bf !== 1'b0) begin failures++;
      $display("FAIL wlast_missing got resp=%b en=%0d late=%0d exp resp=10 en=3 late=0", resp, en, bf); end
    axi_read(12'h040, 8'd6, 3'd2, 2'b01, -1, 0, lat, en, unst);
    for (int b = 0; b < 7; b++) begin
      checks++; if (rd_data_q[b] !== ref_mem[16 + b]) begin failures++;
        $display("FAIL wlast_data word=%0d got=%h exp=%h", 16 + b, rd_data_q[b], ref_mem[16 + b]); end
    end
  endtask

  task automatic test_read_errors();
    int en, lat, unst;
    axi_read(12'h000, 8'd3, 3'd1, 2'b01, -1, 0, lat, en, unst);
    checks++; if (en !== 0) begin failures++; $display("FAIL rsize_mem_en got=%0d exp=0", en); end
    for (int b = 0; b < 4; b++) begin
      checks++; if (rd_data_q[b] !== '0 || rd_resp_q[b] !== 2'b10 || rd_last_q[b] !== (b == 3)) begin failures++;
        $display("FAIL rsize_beat beat=%0d got=%h/%b/%b exp=0/10/%b", b, rd_data_q[b], rd_resp_q[b], rd_last_q[b], b == 3); end
    end
    axi_read(12'h080, 8'd0, 3'd2, 2'b10, -1, 0, lat, en, unst);
    checks++; if (rd_data_q[0] !== '0 || rd_resp_q[0] !== 2'b10 || rd_last_q[0] !== 1'b1 || en !== 0) begin failures++;
      $display("FAIL rburst_err got=%h/%b/%b en=%0d exp=0/10/1 en=0", rd_data_q[0], rd_resp_q[0], rd_last_q[0], en); end
  endtask

  task automatic test_random();
    logic [1:0] resp; int en, lat, unst, len, w; bit bf; logic [75:0] ro;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(0, 7);
      w   = $urandom_range(0, DEPTH - 1 - len);
      axi_write(AW'(w * 4), 8'(len), 3'd2, 2'b01, 1'b1, '0, -1, -1, resp, en, bf, ro);
      checks++; if (resp !== 2'b00 || en !== len + 1) begin failures++;
        $display("FAIL rand_write it=%0d got resp=%b en=%0d exp resp=00 en=%0d", it, resp, en, len + 1); end
      axi_read(AW'(w * 4), 8'(len), 3'd2, 2'b01, -1, 0, lat, en, unst);
      for (int b = 0; b <= len; b++) begin
        checks++; if (rd_data_q[b] !== ref_mem[w + b] || rd_last_q[b] !== (b == len)) begin failures++;
          $display("FAIL rand_read it=%0d word=%0d got=%h/%b exp=%h/%b", it, w + b, rd_data_q[b], rd_last_q[b], ref_mem[w + b], b == len); end
      end
    end
  endtask

  task automatic test_read_stall();
    int en, lat, unst, w;
    w = $urandom_range(0, DEPTH - 4);
    axi_read(AW'(w * 4), 8'd3, 3'd2, 2'b01, 1, 5, lat, en, unst);
    checks++; if (unst !== 0) begin failures++; $display("FAIL stall_stable unstable_cycles=%0d exp=0", unst); end
    checks++; if (en !== 4) begin failures++; $display("FAIL stall_mem_en got=%0d exp=4", en); end
    for (int b = 0; b < 4; b++) begin
      checks++; if (rd_data_q[b] !== ref_mem[w + b]) begin failures++;
        $display("FAIL stall_data word=%0d got=%h exp=%h", w + b, rd_data_q[b], ref_mem[w + b]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] resp; int en, lat, unst; bit bf; logic [75:0] ro;
    axi_write(12'h200, 8'd7, 3'd2, 2'b01, 1'b1, '0, -1, 3, resp, en, bf, ro);
    checks++; if (ro !== '0) begin failures++; $display("FAIL midrst_outputs got=%h exp=0", ro); end
    checks++; if (bf !== 1'b0) begin failures++; $display("FAIL midrst_bvalid got=1 exp=0"); end
    checks++; if (en !== 3) begin failures++; $display("FAIL midrst_mem_en got=%0d exp=3", en); end
    axi_read(12'h200, 8'd7, 3'd2, 2'b01, -1, 0, lat, en, unst);
    for (int b = 0; b < 8; b++) begin
      checks++; if (rd_data_q[b] !== ref_mem[128 + b]) begin failures++;
        $display("FAIL midrst_data word=%0d got=%h exp=%h", 128 + b, rd_data_q[b], ref_mem[128 + b]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = $urandom;
      mem[i] <= ref_mem[i];
    end
    test_reset();
    test_arbitration();
    test_basic();
    test_write_errors();
    test_read_errors();
    test_random();
    test_read_stall();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
